wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back/branch-resolve stage; consumes the EX/WB pipeline register outputs.
//  Selects the register-file write value and keeps the Z/N flag register.
//  Resolves BRZ/BRN/J/JM into a one-cycle PC redirect with target.
//  Squashes the FLUSH_DEPTH younger instructions already in flight after a taken redirect.
// PARAMETERS
//  FLUSH_DEPTH  3  cycles squashed after a redirect (1..7)
//  RD_W         6  register-address width (64 GPRs)
// PORTS
//  clock               in   1   rising-edge clock; sole clock domain
//  reset               in   1   synchronous, active-high reset
//  valid_wb            in   1   instruction in WB slot is real (0 = bubble)
//  writeBackControl_wb in   2   00 ALU, 01 mem readData, 10 pc_plus_y (SVPC), 11 reserved->ALU
//  regWrt_wb           in   1   instruction writes rd
//  rd_wb               in   RD_W destination register
//  branchZero_wb       in   1   BRZ
//  branchNeg_wb        in   1   BRN
//  jump_wb             in   1   J  (target = xrs)
//  jumpMem_wb          in   1   JM (target = readData)
//  pc_plus_y_wb        in   32  PC+y value
//  xrs_wb              in   32  x[rs], branch/jump target
//  readData_wb         in   32  data-memory read value
//  aluResult_wb        in   32  ALU result
//  z_wb, n_wb          in   1   ALU flags produced by this instruction
//  reg_wr_en           out  1   register-file write enable
//  reg_wr_addr         out  RD_W register-file write address
//  reg_wr_data         out  32  register-file write data
//  pc_redirect         out  1   one-cycle pulse: fetch loads pc_target
//  pc_target           out  32  redirect target
//  flag_z, flag_n      out  1   architectural flag register
//  flushing            out  1   high while in FLUSH state
// BEHAVIOUR
//  - All outputs registered; 1-cycle latency from WB inputs. Reset: all outputs 0, state IDLE, cnt 0.
//  - live = valid_wb & (state==IDLE). Inputs with live=0 have no architectural effect.
//  - Write: reg_wr_en <= live & regWrt_wb; addr/data <= rd_wb / mux(writeBackControl_wb).
//    reg_wr_addr/reg_wr_data hold their last value when reg_wr_en=0.
//  - Flags: on live & regWrt_wb & writeBackControl_wb==00: flag_z<=z_wb, flag_n<=n_wb.
//    Otherwise flags hold.
//  - Branch evaluation uses flag_z/flag_n as held BEFORE this instruction, never z_wb/n_wb.
//  - taken = live & (jump_wb | jumpMem_wb | (branchZero_wb&flag_z) | (branchNeg_wb&flag_n)).
//    pc_target <= jumpMem_wb ? readData_wb : xrs_wb; pc_redirect <= taken (1 cycle).
//  - Write and taken in the same instruction both occur (e.g. SVPC+J).
//  - FSM IDLE: taken -> FLUSH, cnt<=FLUSH_DEPTH-1.
//    FSM FLUSH: counts cycles, not valid instructions; cnt==0 -> IDLE, else cnt-1.
//  - In FLUSH: no write, no flag update, no redirect. A branch in the shadow is dropped.
//  - reset in any state overrides everything, including an in-flight FLUSH -> IDLE, cnt 0.
// CONFIGURATION
//  WB_FWD_EN defined: adds fwd_valid(1), fwd_rd(RD_W), fwd_data(32) outputs.
//    These are combinational (same cycle) copies of the next write, for the EX operand bypass.
//    fwd_valid = live & regWrt_wb.
//  WB_FWD_EN undefined: these ports and their logic are absent; stage behaviour is otherwise identical.
// TESTING
//  1. ALU write: valid, wbc=00, regWrt, rd=5, alu=0x1234, z=0,n=1
//     -> next cycle reg_wr_en=1, addr=5, data=0x1234, flag_n=1.
//  2. mem/SVPC mux: wbc=01 readData=0xDEAD -> data 0xDEAD; wbc=10 pc_plus_y=0x40 -> data 0x40;
//     wbc=11 -> aluResult.
//  3. BRZ taken: ALU op with z=1, then BRZ xrs=0x80 -> pc_redirect pulse 1 cycle, pc_target=0x80;
//     the next 3 valid writes are suppressed; the 4th write lands.
//  4. JM in shadow: J xrs=0x10, then JM next cycle -> single redirect to 0x10;
//     JM ignored; flags unchanged during FLUSH.
//  5. Reset mid-FLUSH: reset after J -> flushing=0, all outputs 0;
//     the first valid write after reset completes normally.
//  6. Bubbles/WB_FWD_EN: valid_wb=0 with regWrt=1 -> no write, fwd_valid=0;
//     with the macro, a live write shows fwd_rd/fwd_data in the same cycle.

Source files
------------

// File: rtl/wb_stage_if.sv
// WB-stage bundle: EX/WB pipeline register outputs in, register-file/PC/flag outputs back.
// WB_FWD_EN adds the same-cycle bypass signals.
interface wb_stage_if #(
  parameter int unsigned RD_W = 6
);
  logic            valid_wb;
  logic [1:0]      writeBackControl_wb;
  logic            regWrt_wb;
  logic [RD_W-1:0] rd_wb;
  logic            branchZero_wb;
  logic            branchNeg_wb;
  logic            jump_wb;
  logic            jumpMem_wb;
  logic [31:0]     pc_plus_y_wb;
  logic [31:0]     xrs_wb;
  logic [31:0]     readData_wb;
  logic [31:0]     aluResult_wb;
  logic            z_wb;
  logic            n_wb;

  logic            reg_wr_en;
  logic [RD_W-1:0] reg_wr_addr;
  logic [31:0]     reg_wr_data;
  logic            pc_redirect;
  logic [31:0]     pc_target;
  logic            flag_z;
  logic            flag_n;
  logic            flushing;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [RD_W-1:0] fwd_rd;
  logic [31:0]     fwd_data;
`endif

  modport master (
    output valid_wb, writeBackControl_wb, regWrt_wb, rd_wb,
    output branchZero_wb, branchNeg_wb, jump_wb, jumpMem_wb,
    output pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb, z_wb, n_wb,
    input  reg_wr_en, reg_wr_addr, reg_wr_data, pc_redirect, pc_target,
    input  flag_z, flag_n, flushing
`ifdef WB_FWD_EN
    , input fwd_valid, fwd_rd, fwd_data
`endif
  );

  modport slave (
    input  valid_wb, writeBackControl_wb, regWrt_wb, rd_wb,
    input  branchZero_wb, branchNeg_wb, jump_wb, jumpMem_wb,
    input  pc_plus_y_wb, xrs_wb, readData_wb, aluResult_wb, z_wb, n_wb,
    output reg_wr_en, reg_wr_addr, reg_wr_data, pc_redirect, pc_target,
    output flag_z, flag_n, flushing
`ifdef WB_FWD_EN
    , output fwd_valid, fwd_rd, fwd_data
`endif
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back / branch-resolve stage: register-file write, Z/N flags, PC redirect and shadow flush.
// Optional macro WB_FWD_EN adds combinational fwd_valid/fwd_rd/fwd_data bypass outputs.
module wb_stage #(
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned RD_W        = 6
) (
  input  logic       clock,
  input  logic       reset,
  wb_stage_if.slave  wb
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic            live;
  logic            wr_live;
  logic            taken;
  logic [RD_W-1:0] wr_addr;
  logic [31:0]     wr_data;

  assign live    = wb.valid_wb && (state == IDLE);
  assign wr_live = live && wb.regWrt_wb;
  assign wr_addr = wb.rd_wb;

  // Branches test the flags as they stood before this instruction, not z_wb/n_wb.
  assign taken = live && (wb.jump_wb || wb.jumpMem_wb ||
                          (wb.branchZero_wb && wb.flag_z) ||
                          (wb.branchNeg_wb  && wb.flag_n));

  always_comb begin
    wr_data = wb.aluResult_wb;
    case (wb.writeBackControl_wb)
      2'b01:   wr_data = wb.readData_wb;
      2'b10:   wr_data = wb.pc_plus_y_wb;
      default: wr_data = wb.aluResult_wb;
    endcase
  end

  // Shadow length counts clock cycles, independent of how many slots are valid.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (taken) begin
          state_nxt = FLUSH;
          cnt_nxt   = 3'(FLUSH_DEPTH - 1);
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb.reg_wr_en   <= 1'b0;
      wb.reg_wr_addr <= '0;
      wb.reg_wr_data <= '0;
      wb.pc_redirect <= 1'b0;
      wb.pc_target   <= '0;
      wb.flag_z      <= 1'b0;
      wb.flag_n      <= 1'b0;
    end else begin
      wb.reg_wr_en   <= wr_live;
      wb.pc_redirect <= taken;
      if (wr_live) begin
        wb.reg_wr_addr <= wr_addr;
        wb.reg_wr_data <= wr_data;
      end
      if (wr_live && (wb.writeBackControl_wb == 2'b00)) begin
        wb.flag_z <= wb.z_wb;
        wb.flag_n <= wb.n_wb;
      end
      if (taken) begin
        wb.pc_target <= wb.jumpMem_wb ? wb.readData_wb : wb.xrs_wb;
      end
    end
  end

  assign wb.flushing = (state == FLUSH);

`ifdef WB_FWD_EN
  assign wb.fwd_valid = wr_live;
  assign wb.fwd_rd    = wr_addr;
  assign wb.fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push hand-computed expectations,
// a monitor pops and compares one expectation per registered output cycle.
module tb_wb_stage;

  logic clock;
  logic reset;

  wb_stage_if #(.RD_W(6)) wb ();

  wb_stage #(.FLUSH_DEPTH(3), .RD_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (wb.slave)
  );

  typedef struct {
    logic        en;
    logic [5:0]  a;
    logic [31:0] d;
    logic        redir;
    logic [31:0] t;
    logic        tchk;
    logic        fz;
    logic        fn;
    logic        fl;
  } exp_t;

  exp_t q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t E(input logic en, input logic [5:0] a, input logic [31:0] d,
                             input logic redir, input logic [31:0] t, input logic tchk,
                             input logic fz, input logic fn, input logic fl);
    exp_t e;
    e.en = en; e.a = a; e.d = d; e.redir = redir; e.t = t; e.tchk = tchk;
    e.fz = fz; e.fn = fn; e.fl = fl;
    return e;
  endfunction

  // Start of a cycle: wait for the falling edge, then clear all stimulus.
  task automatic cyc();
    @(negedge clock);
    reset                  = 1'b0;
    wb.valid_wb            = 1'b0;
    wb.writeBackControl_wb = 2'b00;
    wb.regWrt_wb           = 1'b0;
    wb.rd_wb               = '0;
    wb.branchZero_wb       = 1'b0;
    wb.branchNeg_wb        = 1'b0;
    wb.jump_wb             = 1'b0;
    wb.jumpMem_wb          = 1'b0;
    wb.pc_plus_y_wb        = '0;
    wb.xrs_wb              = '0;
    wb.readData_wb         = '0;
    wb.aluResult_wb        = '0;
    wb.z_wb                = 1'b0;
    wb.n_wb                = 1'b0;
  endtask

  task automatic push(input exp_t e);
    q.push_back(e);
`ifdef WB_FWD_EN
    #1;
    if (!reset) begin
      chk("fwd_valid", {31'd0, wb.fwd_valid}, {31'd0, e.en});
      if (e.en) begin
        chk("fwd_rd", {26'd0, wb.fwd_rd}, {26'd0, e.a});
        chk("fwd_data", wb.fwd_data, e.d);
      end
    end
`endif
  endtask

  // Monitor: every registered output cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("reg_wr_en",   {31'd0, wb.reg_wr_en},   {31'd0, e.en});
        chk("reg_wr_addr", {26'd0, wb.reg_wr_addr}, {26'd0, e.a});
        chk("reg_wr_data", wb.reg_wr_data, e.d);
        chk("pc_redirect", {31'd0, wb.pc_redirect}, {31'd0, e.redir});
        if (e.redir || e.tchk) chk("pc_target", wb.pc_target, e.t);
        chk("flag_z",   {31'd0, wb.flag_z},   {31'd0, e.fz});
        chk("flag_n",   {31'd0, wb.flag_n},   {31'd0, e.fn});
        chk("flushing", {31'd0, wb.flushing}, {31'd0, e.fl});
      end
    end
  end

  initial begin
    reset = 1'b1;
    // Reset state
    cyc(); reset = 1'b1;
    push(E(0, 6'd0, 32'h0, 0, 32'h0, 1, 0, 0, 0));
    cyc(); reset = 1'b1;
    push(E(0, 6'd0, 32'h0, 0, 32'h0, 1, 0, 0, 0));

    // ALU write sets flags
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 5; wb.aluResult_wb = 32'h1234; wb.n_wb = 1;
    push(E(1, 6'd5, 32'h1234, 0, 0, 0, 0, 1, 0));
    // Mux: mem, SVPC, reserved; flags must hold on non-ALU writes
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 6; wb.writeBackControl_wb = 2'b01;
    wb.readData_wb = 32'hDEAD; wb.z_wb = 1;
    push(E(1, 6'd6, 32'hDEAD, 0, 0, 0, 0, 1, 0));
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 7; wb.writeBackControl_wb = 2'b10;
    wb.pc_plus_y_wb = 32'h40; wb.aluResult_wb = 32'h55;
    push(E(1, 6'd7, 32'h40, 0, 0, 0, 0, 1, 0));
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 8; wb.writeBackControl_wb = 2'b11;
    wb.aluResult_wb = 32'h77; wb.readData_wb = 32'h66; wb.z_wb = 1;
    push(E(1, 6'd8, 32'h77, 0, 0, 0, 0, 1, 0));
    // Bubble with regWrt: no write, addr/data/flags hold
    cyc(); wb.regWrt_wb = 1; wb.rd_wb = 9; wb.aluResult_wb = 32'h99; wb.z_wb = 1;
    push(E(0, 6'd8, 32'h77, 0, 0, 0, 0, 1, 0));

    // BRZ taken after z=1, three shadow writes dropped, fourth lands
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 10; wb.z_wb = 1;
    push(E(1, 6'd10, 32'h0, 0, 0, 0, 1, 0, 0));
    cyc(); wb.valid_wb = 1; wb.branchZero_wb = 1; wb.xrs_wb = 32'h80;
    push(E(0, 6'd10, 32'h0, 1, 32'h80, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++) begin
      cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 6'(11 + i);
      wb.aluResult_wb = 32'h11 + i; wb.n_wb = 1;
      push(E(0, 6'd10, 32'h0, 0, 0, 0, 1, 0, (i < 2) ? 1'b1 : 1'b0));
    end
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 14; wb.aluResult_wb = 32'h14;
    push(E(1, 6'd14, 32'h14, 0, 0, 0, 0, 0, 0));

    // BRN uses the old flag_n even when the same instruction sets n
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 15; wb.aluResult_wb = 32'h5;
    wb.n_wb = 1; wb.branchNeg_wb = 1; wb.xrs_wb = 32'hA0;
    push(E(1, 6'd15, 32'h5, 0, 0, 0, 0, 1, 0));
    cyc(); wb.valid_wb = 1; wb.branchNeg_wb = 1; wb.xrs_wb = 32'hB0;
    push(E(0, 6'd15, 32'h5, 1, 32'hB0, 0, 0, 1, 1));
    cyc(); wb.valid_wb = 1; wb.jumpMem_wb = 1; wb.readData_wb = 32'h300;
    push(E(0, 6'd15, 32'h5, 0, 0, 0, 0, 1, 1));
    cyc();
    push(E(0, 6'd15, 32'h5, 0, 0, 0, 0, 1, 1));
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 16; wb.aluResult_wb = 32'h16; wb.z_wb = 1;
    push(E(0, 6'd15, 32'h5, 0, 0, 0, 0, 1, 0));

    // SVPC+J: write and redirect together; JM in the shadow is ignored
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 20; wb.writeBackControl_wb = 2'b10;
    wb.pc_plus_y_wb = 32'h44; wb.jump_wb = 1; wb.xrs_wb = 32'h10;
    push(E(1, 6'd20, 32'h44, 1, 32'h10, 0, 0, 1, 1));
    cyc(); wb.valid_wb = 1; wb.jumpMem_wb = 1; wb.readData_wb = 32'h200; wb.regWrt_wb = 1;
    wb.rd_wb = 21; wb.aluResult_wb = 32'h21; wb.z_wb = 1;
    push(E(0, 6'd20, 32'h44, 0, 0, 0, 0, 1, 1));
    cyc();
    push(E(0, 6'd20, 32'h44, 0, 0, 0, 0, 1, 1));
    cyc();
    push(E(0, 6'd20, 32'h44, 0, 0, 0, 0, 1, 0));

    // JM taken, then reset mid-flush, then a normal write
    cyc(); wb.valid_wb = 1; wb.jumpMem_wb = 1; wb.readData_wb = 32'h300; wb.xrs_wb = 32'h10;
    push(E(0, 6'd20, 32'h44, 1, 32'h300, 0, 0, 1, 1));
    cyc(); reset = 1; wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 30; wb.aluResult_wb = 32'h30;
    wb.jump_wb = 1; wb.xrs_wb = 32'h50;
    push(E(0, 6'd0, 32'h0, 0, 32'h0, 1, 0, 0, 0));
    cyc(); wb.valid_wb = 1; wb.regWrt_wb = 1; wb.rd_wb = 3; wb.aluResult_wb = 32'hABC; wb.z_wb = 1;
    push(E(1, 6'd3, 32'hABC, 0, 0, 0, 1, 0, 0));
    cyc();
    push(E(0, 6'd3, 32'hABC, 0, 0, 0, 1, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
